mem_access_unit: RTL and testbench

- Initiator-side controller that sits between the datapath's load/store stage and the data memory wrapper.
- Accepts one load or store request at a time via a valid/ready handshake and drives the memory's `mem_read`/`mem_write`/`address`/`data_in` pins.
- Waits out the memory's registered read latency, then returns sign- or zero-extended load data through a response handshake.
- Implements byte and halfword stores as read-modify-write on the word-wide memory.

---
 rtl/mem_access_pkg.sv | 25 ++
 rtl/mem_lane_align.sv | 69 ++++++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and constants for the load/store memory access unit.
package mem_access_pkg;

  // Access size encodings as presented on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Supported range of memory read latency
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_WAIT,
    ST_RMW_WAIT,
    ST_RESP
  } state_t;

  function automatic bit latency_in_range(input int lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: load extract/extend, store merge, alignment check.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        zero_ext,
  input  logic [31:0] rdata,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] store_rep;
  logic [3:0]  byte_en;

  // Pick the addressed byte and halfword out of the read word (little-endian)
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected lane to 32 bits
  always_comb begin
    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = zero_ext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = zero_ext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Replicate store data across lanes and work out which bytes it replaces
  always_comb begin
    byte_en   = 4'b1111;
    store_rep = {2{store_data}};
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        store_rep = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{store_data}};
      end
      default: begin
        byte_en   = 4'b1111;
        store_rep = {2{store_data}};
      end
    endcase
  end

  // Per-lane merge of store data into the word read back from memory
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = byte_en[gi] ? store_rep[8*gi +: 8] : rdata[8*gi +: 8];
    end
  endgenerate

  // Illegal size, odd halfword, or word not on a 4-byte boundary
  assign misaligned = (size == 2'b11)
                   || ((size == SZ_HALF) && addr_lo[0])
                   || ((size == SZ_WORD) && (addr_lo != 2'b00));

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, waits out read latency,
// performs sub-word stores as read-modify-write, returns extended load data.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  generate
    if (!latency_in_range(MEM_LATENCY)) begin : g_bad_latency
      $error("mem_access_unit: MEM_LATENCY must be between 1 and 4");
    end
  endgenerate

  localparam logic [2:0] LAT_CNT = 3'(MEM_LATENCY);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [1:0]  size_reg, size_next;
  logic        zero_ext_reg, zero_ext_next;
  logic [1:0]  addr_lo_reg, addr_lo_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;
  logic        mem_read_reg, mem_read_next;
  logic        mem_write_reg, mem_write_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;

  logic        is_idle;
  logic [1:0]  align_size;
  logic [1:0]  align_addr_lo;
  logic        align_zero_ext;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        misaligned;

  // In IDLE the aligner checks the live request; afterwards it uses the captured fields
  assign is_idle        = (state_reg == ST_IDLE);
  assign align_size     = is_idle ? req_size : size_reg;
  assign align_addr_lo  = is_idle ? req_addr[1:0] : addr_lo_reg;
  assign align_zero_ext = is_idle ? req_unsigned : zero_ext_reg;

  mem_lane_align u_align (
    .size        (align_size),
    .addr_lo     (align_addr_lo),
    .zero_ext    (align_zero_ext),
    .rdata       (mem_rdata),
    .store_data  (wdata_reg),
    .load_data   (load_data),
    .merged_word (merged_word),
    .misaligned  (misaligned)
  );

  // Next-state and next-register logic; memory strobes default low so they pulse once
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    size_next      = size_reg;
    zero_ext_next  = zero_ext_reg;
    addr_lo_next   = addr_lo_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    err_next       = err_reg;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          size_next     = req_size;
          zero_ext_next = req_unsigned;
          addr_lo_next  = req_addr[1:0];
          wdata_next    = req_wdata[15:0];
          rdata_next    = 32'h0;
          err_next      = misaligned;
          cnt_next      = 3'd0;
          if (misaligned) begin
            state_next = ST_RESP;
          end else begin
            mem_addr_next = 32'(req_addr[ADDR_W-1:2]);
            if (req_write && (req_size == SZ_WORD)) begin
              mem_write_next = 1'b1;
              mem_wdata_next = req_wdata;
              state_next     = ST_WRITE;
            end else begin
              mem_read_next = 1'b1;
              state_next    = req_write ? ST_RMW_WAIT : ST_RD_WAIT;
            end
          end
        end
      end
      ST_WRITE: begin
        state_next = ST_RESP;
      end
      ST_RD_WAIT: begin
        if (cnt_reg == LAT_CNT) begin
          rdata_next = load_data;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      ST_RMW_WAIT: begin
        if (cnt_reg == LAT_CNT) begin
          mem_wdata_next = merged_word;
          mem_write_next = 1'b1;
          state_next     = ST_WRITE;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 3'd0;
      size_reg      <= SZ_BYTE;
      zero_ext_reg  <= 1'b0;
      addr_lo_reg   <= 2'b00;
      wdata_reg     <= 16'h0;
      rdata_reg     <= 32'h0;
      err_reg       <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= 32'h0;
      mem_wdata_reg <= 32'h0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      size_reg      <= size_next;
      zero_ext_reg  <= zero_ext_next;
      addr_lo_reg   <= addr_lo_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  assign req_ready  = is_idle;
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;
  assign mem_read   = mem_read_reg;
  assign mem_write  = mem_write_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit at MEM_LATENCY=1 (dut) and MEM_LATENCY=3 (dut3).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid3 = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_ready = 1'b1;

  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        req_ready3, resp_valid3, resp_err3, mem_read3, mem_write3;
  logic [31:0] resp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  int tests_run = 0;
  int tests_failed = 0;

  // Preload port shared by both memory models
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = 4'h0;
  logic [31:0] pre_val = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_LATENCY(1), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.MEM_LATENCY(3), .ADDR_W(32)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid3),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata3), .resp_err(resp_err3),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // Latency-1 memory: data valid only in the single cycle after the read pulse
  logic [31:0] mem1 [0:15];
  logic        rv1 = 1'b0;
  logic [31:0] rd1 = 32'h0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  always @(posedge clk) begin
    if (pre_we) mem1[pre_idx] <= pre_val;
    if (mem_write) begin
      mem1[mem_addr[3:0]] <= mem_wdata;
      wr_pulses <= wr_pulses + 1;
    end
    if (mem_read) rd_pulses <= rd_pulses + 1;
    rv1 <= mem_read;
    rd1 <= mem1[mem_addr[3:0]];
  end
  assign mem_rdata = rv1 ? rd1 : 32'hBAD0BAD0;

  // Latency-3 memory: read data appears three cycles after the read pulse
  logic [31:0] mem3 [0:15];
  logic [2:0]  rv3 = 3'b000;
  logic [31:0] rd3 [0:2];
  always @(posedge clk) begin
    if (pre_we) mem3[pre_idx] <= pre_val;
    rv3    <= {rv3[1:0], mem_read3};
    rd3[0] <= mem3[mem_addr3[3:0]];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign mem_rdata3 = rv3[2] ? rd3[2] : 32'hBAD0BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    tick();
    pre_we  = 1'b0;
  endtask

  // Present a request to dut for one edge; returns in cycle 1
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    $display("[TB] request write=%0d size=%0d unsigned=%0d addr=0x%08h wdata=0x%08h", w, sz, u, a, d);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    tests_run++; if (resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
    tests_run++; if (resp_err !== 1'b0) begin tests_failed++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    tests_run++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin tests_failed++; $display("FAIL rst_strobes: got rd=%b wr=%b want 0 0", mem_read, mem_write); end
    tests_run++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL rst_mem_bus: got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_word_store();
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL ws_ready: got %b want 1", req_ready); end
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    tests_run++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin tests_failed++; $display("FAIL ws_c1_strobes: got wr=%b rd=%b want 1 0", mem_write, mem_read); end
    tests_run++; if (mem_addr !== 32'h4) begin tests_failed++; $display("FAIL ws_c1_addr: got %h want 4", mem_addr); end
    tests_run++; if (mem_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL ws_c1_wdata: got %h want deadbeef", mem_wdata); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL ws_c1_resp: got %b want 0", resp_valid); end
    tick();
    tests_run++; if (resp_valid !== 1'b1 || mem_write !== 1'b0) begin tests_failed++; $display("FAIL ws_c2: got resp_valid=%b mem_write=%b want 1 0", resp_valid, mem_write); end
    tests_run++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin tests_failed++; $display("FAIL ws_c2_resp: got rdata=%h err=%b want 0 0", resp_rdata, resp_err); end
    tick();
    tests_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL ws_c3_idle: got resp_valid=%b req_ready=%b want 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_word_load();
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tests_run++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h4) begin tests_failed++; $display("FAIL wl_c1: got rd=%b wr=%b addr=%h want 1 0 4", mem_read, mem_write, mem_addr); end
    tick();
    tests_run++; if (mem_read !== 1'b0 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL wl_c2: got rd=%b resp_valid=%b want 0 0", mem_read, resp_valid); end
    tick();
    tests_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wl_c3: got valid=%b rdata=%h want 1 deadbeef", resp_valid, resp_rdata); end
    tick();
  endtask

  task automatic test_sub_load();
    poke(4'h4, 32'h12348056);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    tick(); tick();
    tests_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb_signed: got valid=%b rdata=%h want 1 ffffff80", resp_valid, resp_rdata); end
    tick();
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    tick(); tick();
    tests_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h00000080) begin tests_failed++; $display("FAIL lb_unsigned: got valid=%b rdata=%h want 1 00000080", resp_valid, resp_rdata); end
    tick();
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    tick(); tick();
    tests_run++; if (resp_rdata !== 32'h00001234) begin tests_failed++; $display("FAIL lh_upper: got %h want 00001234", resp_rdata); end
    tick();
    issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    tick(); tick();
    tests_run++; if (resp_rdata !== 32'hFFFF8056) begin tests_failed++; $display("FAIL lh_lower_signed: got %h want ffff8056", resp_rdata); end
    tick();
  endtask

  task automatic test_byte_store();
    poke(4'h4, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h555555AB);
    tests_run++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin tests_failed++; $display("FAIL sb_c1: got rd=%b wr=%b want 1 0", mem_read, mem_write); end
    tick();
    tests_run++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin tests_failed++; $display("FAIL sb_c2: got rd=%b wr=%b want 0 0", mem_read, mem_write); end
    tick();
    tests_run++; if (mem_write !== 1'b1 || mem_wdata !== 32'h11AB3344 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL sb_c3: got wr=%b wdata=%h valid=%b want 1 11ab3344 0", mem_write, mem_wdata, resp_valid); end
    tick();
    tests_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || mem_write !== 1'b0) begin tests_failed++; $display("FAIL sb_c4: got valid=%b rdata=%h wr=%b want 1 0 0", resp_valid, resp_rdata, mem_write); end
    tick();
    tests_run++; if (mem1[4] !== 32'h11AB3344) begin tests_failed++; $display("FAIL sb_mem: got %h want 11ab3344", mem1[4]); end
  endtask

  task automatic test_errors();
    int rd0, wr0;
    rd0 = rd_pulses; wr0 = wr_pulses;
    issue(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    tests_run++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin tests_failed++; $display("FAIL err_half: got valid=%b err=%b want 1 1", resp_valid, resp_err); end
    tests_run++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin tests_failed++; $display("FAIL err_half_strobes: got rd=%b wr=%b want 0 0", mem_read, mem_write); end
    tick();
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678);
    tests_run++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin tests_failed++; $display("FAIL err_size: got valid=%b err=%b want 1 1", resp_valid, resp_err); end
    tick();
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    tests_run++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin tests_failed++; $display("FAIL err_word: got valid=%b err=%b want 1 1", resp_valid, resp_err); end
    tick(); tick();
    tests_run++; if (rd_pulses !== rd0 || wr_pulses !== wr0) begin tests_failed++; $display("FAIL err_no_access: got rd=%0d wr=%0d pulses want 0 0", rd_pulses - rd0, wr_pulses - wr0); end
  endtask

  task automatic test_back_to_back();
    poke(4'h5, 32'hCAFEF00D);
    resp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11AB3344 || req_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_%0d: got valid=%b rdata=%h ready=%b want 1 11ab3344 0", i, resp_valid, resp_rdata, req_ready); end
      if (i == 0) begin
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h14; req_wdata = 32'h0;
        req_valid = 1'b1;
        $display("[TB] request write=0 size=2 unsigned=0 addr=0x00000014 wdata=0x00000000 (held during stall)");
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    tests_run++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got ready=%b valid=%b want 1 0", req_ready, resp_valid); end
    tick();
    tests_run++; if (mem_read !== 1'b1 || mem_addr !== 32'h5) begin tests_failed++; $display("FAIL b2b_accept: got rd=%b addr=%h want 1 5", mem_read, mem_addr); end
    req_valid = 1'b0;
    tick(); tick();
    tests_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL b2b_data: got valid=%b rdata=%h want 1 cafef00d", resp_valid, resp_rdata); end
    tick();
  endtask

  task automatic test_reset_abort();
    int wr0;
    poke(4'h4, 32'h11223344);
    wr0 = wr_pulses;
    issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h00000099);
    tests_run++; if (mem_read !== 1'b1) begin tests_failed++; $display("FAIL abort_read: got %b want 1", mem_read); end
    tick();
    reset = 1'b1;
    #1;
    tests_run++; if (mem_addr !== 32'h0 || mem_read !== 1'b0 || mem_write !== 1'b0 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_outputs: got addr=%h rd=%b wr=%b valid=%b want 0 0 0 0", mem_addr, mem_read, mem_write, resp_valid); end
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    tests_run++; if (wr_pulses !== wr0 || mem1[4] !== 32'h11223344) begin tests_failed++; $display("FAIL abort_no_write: got writes=%0d mem=%h want 0 11223344", wr_pulses - wr0, mem1[4]); end
    tests_run++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_release: got ready=%b valid=%b want 1 0", req_ready, resp_valid); end
  endtask

  task automatic test_latency3();
    poke(4'h4, 32'h87654321);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid3 = 1'b1;
    $display("[TB] request(lat3) write=0 size=2 unsigned=0 addr=0x00000010");
    tick();
    req_valid3 = 1'b0;
    tests_run++; if (mem_read3 !== 1'b1 || mem_addr3 !== 32'h4) begin tests_failed++; $display("FAIL l3_c1: got rd=%b addr=%h want 1 4", mem_read3, mem_addr3); end
    tick();
    tests_run++; if (mem_read3 !== 1'b0) begin tests_failed++; $display("FAIL l3_c2_pulse: got %b want 0", mem_read3); end
    tick(); tick();
    tests_run++; if (resp_valid3 !== 1'b0) begin tests_failed++; $display("FAIL l3_c4_early: got %b want 0", resp_valid3); end
    tick();
    tests_run++; if (resp_valid3 !== 1'b1 || resp_rdata3 !== 32'h87654321) begin tests_failed++; $display("FAIL l3_c5: got valid=%b rdata=%h want 1 87654321", resp_valid3, resp_rdata3); end
    tick();
    req_size = 2'b00; req_addr = 32'h13;
    req_valid3 = 1'b1;
    $display("[TB] request(lat3) write=0 size=0 unsigned=0 addr=0x00000013");
    tick();
    req_valid3 = 1'b0;
    tick(); tick(); tick(); tick();
    tests_run++; if (resp_valid3 !== 1'b1 || resp_rdata3 !== 32'hFFFFFF87) begin tests_failed++; $display("FAIL l3_byte: got valid=%b rdata=%h want 1 ffffff87", resp_valid3, resp_rdata3); end
    tick();
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_word_load();
    test_sub_load();
    test_byte_store();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_latency3();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
